// File: rtl/mem_port_arbiter4.sv
// mem_port_arbiter4: round-robin owner arbiter for a shared 4-input port.
// It produces a registered one-hot grant plus a 2-bit mux select. A grant
// is held until the owner drops its request or strobes done, and the next
// requester is handed the port on the same edge, with no idle cycle.
// Optional macro ARB_TIMEOUT_EN adds a hold counter. The counter forces a
// release after MAX_HOLD cycles and pulses timeout for one cycle.
// Handshake: req[i] is a level request. done[i] is read only while
// requester i is the owner. gnt[i] is the only acknowledge, and it changes
// only at a release edge or a reset edge.
module mem_port_arbiter4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout,
    output logic       dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;
    logic [1:0] ptr_q;
    logic       busy_q;
    logic       timeout_q;

    logic [1:0] owner;
    logic       nat_rel;
    logic       force_rel;
    logic       rel;
    logic [1:0] arb_ptr;
    logic       win_found;
    logic [1:0] win_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    logic [HW-1:0] hold_q;
`endif

    // First requester found when scanning from p upwards, wrapping mod 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic       found;
        logic [1:0] w;
        logic [1:0] idx;
        found = 1'b0;
        w     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        return {found, w};
    endfunction

    // Release detection and next winner. On release, the old owner drops to lowest priority.
    always_comb begin
        owner   = sel_q;
        nat_rel = done[owner] | ~req[owner];
`ifdef ARB_TIMEOUT_EN
        force_rel = (hold_q == HOLD_LAST);
`else
        force_rel = 1'b0;
`endif
        rel     = (state_q == GRANT) && (nat_rel || force_rel);
        arb_ptr = rel ? 2'(owner + 2'd1) : ptr_q;
        {win_found, win_idx} = pick(req, arb_ptr);
    end

    // Arbiter FSM with registered grant, select, busy and timeout outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'b00;
            ptr_q     <= 2'b00;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (win_found) begin
                        state_q <= GRANT;
                        gnt_q   <= 4'b0001 << win_idx;
                        sel_q   <= win_idx;
                        busy_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (rel) begin
                        ptr_q     <= arb_ptr;
                        timeout_q <= force_rel & ~nat_rel;
`ifdef ARB_TIMEOUT_EN
                        hold_q    <= '0;
`endif
                        if (win_found) begin
                            gnt_q <= 4'b0001 << win_idx;
                            sel_q <= win_idx;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= 4'b0000;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                        hold_q    <= hold_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter4.sv
// Directed bench for mem_port_arbiter4 (MAX_HOLD=4); covers reset, rotation,
// release to idle, request drop, stray done, mid-grant reset and hold limit.
module tb_mem_port_arbiter4;

    // clock / reset block
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
    logic       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic t);
        check({tag, ".gnt"},     8'(gnt),     8'(g));
        check({tag, ".sel"},     8'(sel),     8'(s));
        check({tag, ".busy"},    8'(busy),    8'(b));
        check({tag, ".timeout"}, 8'(timeout), 8'(t));
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        done = 4'b0000;

        // 1: reset held two cycles with all requests, then first grant to 0
        step(); chk_out("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
        check("rst1.state", 8'(dbg_state), 8'd0);
        step(); chk_out("rst2", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); chk_out("first", 4'b0001, 2'd0, 1'b1, 1'b0);
        check("first.state", 8'(dbg_state), 8'd1);

        // 2: rotation, done on the third grant cycle of each owner
        for (int k = 0; k < 4; k++) begin
            step(); chk_out($sformatf("rot%0d.c2", k), 4'(1 << k), 2'(k), 1'b1, 1'b0);
            step(); chk_out($sformatf("rot%0d.c3", k), 4'(1 << k), 2'(k), 1'b1, 1'b0);
            done = 4'(1 << k);
            step(); done = 4'b0000;
            chk_out($sformatf("rot%0d.next", k), 4'(1 << ((k + 1) % 4)), 2'((k + 1) % 4), 1'b1, 1'b0);
        end

        // 3: only requester 2; owner 0 drops its request, 2 finishes, then idle
        req = 4'b0100;
        step(); chk_out("r2.n1", 4'b0100, 2'd2, 1'b1, 1'b0);
        step(); chk_out("r2.n2", 4'b0100, 2'd2, 1'b1, 1'b0);
        step(); chk_out("r2.n3", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 4'b0100; req = 4'b0000;
        step(); done = 4'b0000;
        chk_out("r2.idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        check("r2.state", 8'(dbg_state), 8'd0);
        step(); chk_out("r2.idle2", 4'b0000, 2'd2, 1'b0, 1'b0);

        // 4: ptr is 3; owner 1 drops request while 3 waits; stray done[2]
        req = 4'b0010;
        step(); chk_out("o1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1000;
        step(); chk_out("o1.drop", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 4'b0100;
        step(); chk_out("stray1", 4'b1000, 2'd3, 1'b1, 1'b0);
        step(); chk_out("stray2", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 4'b0000;

        // 5: grant to 2, then reset in its second cycle with all requests
        req = 4'b0100;
        step(); chk_out("g2.c1", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1111;
        step(); chk_out("g2.c2", 4'b0100, 2'd2, 1'b1, 1'b0);
        rst = 1'b1;
        step(); chk_out("midrst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); chk_out("postrst", 4'b0001, 2'd0, 1'b1, 1'b0);

        // 6: hold limit with req=0011 held and no done
        rst = 1'b1; req = 4'b0011;
        step(); rst = 1'b0;
        step(); chk_out("hold.c1", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= 4; c++) begin
            step(); chk_out($sformatf("hold0.c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step(); chk_out("to1", 4'b0010, 2'd1, 1'b1, 1'b1);
        for (int c = 2; c <= 4; c++) begin
            step(); chk_out($sformatf("hold1.c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step(); chk_out("to2", 4'b0001, 2'd0, 1'b1, 1'b1);
        step(); chk_out("to2.after", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
        for (int c = 2; c <= 12; c++) begin
            step(); chk_out($sformatf("hold.c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter4.md
Name: mem_port_arbiter4

Overview:
- Round-robin arbiter that shares one 4-input resource (e.g. the unified memory port) among up to four requesters.
- Produces the one-hot grant and the 2-bit select that drives the existing 4:1 mux in front of the resource.
- Holds a grant until the owner releases it, and hands off to the next requester with no idle cycle.
- Sits between the pipeline stages or requesters and the shared-port mux4.

Parameters:
- MAX_HOLD, 16: maximum grant length in cycles, used only when ARB_TIMEOUT_EN is defined. Must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i = requester i.
- done  input  4  owner's last-transfer strobe; bit i is meaningful only while requester i is granted.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- sel  output  2  index of the current or last owner; connects to the mux4 select.
- busy  output  1  1 while any grant is active.
- timeout  output  1  1-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high: rst sampled 1 at a rising clk edge forces state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, timeout=0, ptr=0, hold counter=0.
  - rst has priority over all other inputs, including mid-grant: the grant is dropped at that edge with no handoff.
- State and pointer:
  - Two states: IDLE and GRANT.
  - ptr (2 bits) is the highest-priority index for the next arbitration.
- Arbitration function:
  - Winner = first i in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1.
- IDLE:
  - If req != 0: at the next edge, state=GRANT, gnt=onehot(winner), sel=winner, busy=1.
  - Otherwise remain in IDLE; gnt=0, busy=0, sel holds its last value so the mux input stays stable.
- Latency:
  - Exactly 1 cycle from req sampled to gnt asserted.
  - No combinational path from req or done to any output.
- GRANT with owner o:
  - Release condition = done[o] | ~req[o] | forced timeout.
  - On release, ptr_next = o+1 mod 4, then arbitrate over the current req vector using ptr_next:
    - any req set: the next edge grants the winner directly, with no idle cycle;
    - req == 0: the next edge goes to IDLE with gnt=0, busy=0, sel unchanged.
  - An owner that still requests is eligible again, but at lowest priority.
  - With no release condition, gnt, sel and busy hold.
  - done bits of non-owners are ignored.
  - Simultaneous done[o] and new requests: handoff per the rule above.
- Handoff timing:
  - On handoff, ptr updates to o+1 at the same edge the new gnt appears.
  - gnt is never multi-hot and never changes except at a release or reset edge.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A hold counter of width $clog2(MAX_HOLD)+1 clears on every new grant and increments each GRANT cycle.
  - When the owner has held the grant for MAX_HOLD cycles with no release condition, the arbiter force-releases it.
  - The forced release is handled as a normal release, except that timeout=1 for exactly the cycle in which the new gnt (or idle) appears.
  - The counter clears on reset.
- Not defined:
  - No counter exists.
  - A grant is held indefinitely until done or req drop.
  - timeout is tied to 0.

Test Plan:
1. rst=1 for 2 cycles with req=4'b1111 → gnt=0000, sel=00, busy=0 throughout. First edge after rst falls → gnt=0001, sel=00, busy=1.
2. req=1111 held; each owner pulses done on its 3rd grant cycle → grant sequence 0001,0010,0100,1000,0001; each handoff is on the edge after done with no gnt=0 cycle; sel=0,1,2,3,0.
3. req=0100 from cycle N; done[2]=1 at N+3; req=0 from N+3 → gnt=0100, sel=10 at N+1..N+3; gnt=0000, busy=0 at N+4; sel stays 10.
4. Owner 1 granted; req[1] drops with done=0 and req[3]=1 → next edge gnt=1000, sel=11. Stray done[2]=1 while owner is 3 → no change.
5. rst asserted during the 2nd cycle of grant to requester 2 with req=1111 → next edge gnt=0000, busy=0, sel=00. After rst release, grant goes to 0 (ptr reset), not 3.
6. ARB_TIMEOUT_EN, MAX_HOLD=4; req=0011 held; no done → gnt=0001 for 4 cycles, then gnt=0010 with timeout=1 for that single cycle, then 0001 again after 4 more cycles. Macro undefined → gnt=0001 indefinitely; timeout=0.
